// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg -- shared definitions for the 16-bit ALU and its writeback stage.
//   op_idx_e   : bit position of each opcode inside the one-hot op vector
//   wb_state_e : writeback FSM states
//   flags_t    : architectural condition flags {z, c, n, v}
//   OP_W       : width of the one-hot opcode vector
// Opcode class masks and a one-hot test are provided so that every consumer
// decodes the opcode the same way.
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int OP_W = 15;

  typedef logic [OP_W-1:0] op_t;

  typedef enum int unsigned {
    OP_ADD   = 0,
    OP_SUB   = 1,
    OP_CMP   = 2,
    OP_AND   = 3,
    OP_OR    = 4,
    OP_XOR   = 5,
    OP_NOT   = 6,
    OP_NEG   = 7,
    OP_SHL   = 8,
    OP_SHR   = 9,
    OP_ST    = 10,
    OP_LD    = 11,
    OP_MOV   = 12,
    OP_LDUMP = 13,
    OP_SDUMP = 14
  } op_idx_e;

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_MEM  = 2'd1,
    WB_LDWB = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic z;
    logic c;
    logic n;
    logic v;
  } flags_t;

  // Ops that write result[WIDTH-1:0] straight into the register file.
  localparam op_t RF_WRITE_MASK =
      (op_t'(1) << OP_ADD) | (op_t'(1) << OP_SUB)   | (op_t'(1) << OP_AND)   |
      (op_t'(1) << OP_OR)  | (op_t'(1) << OP_XOR)   | (op_t'(1) << OP_NOT)   |
      (op_t'(1) << OP_NEG) | (op_t'(1) << OP_SHL)   | (op_t'(1) << OP_SHR)   |
      (op_t'(1) << OP_MOV) | (op_t'(1) << OP_LDUMP) | (op_t'(1) << OP_SDUMP);

  // Ops that update the condition flags.
  localparam op_t FLAG_MASK =
      (op_t'(1) << OP_ADD) | (op_t'(1) << OP_SUB) | (op_t'(1) << OP_CMP) |
      (op_t'(1) << OP_AND) | (op_t'(1) << OP_OR)  | (op_t'(1) << OP_XOR) |
      (op_t'(1) << OP_NOT) | (op_t'(1) << OP_NEG) | (op_t'(1) << OP_SHL) |
      (op_t'(1) << OP_SHR);

  // Flag-updating ops whose carry comes from result[WIDTH]; the logic ops
  // clear C instead.
  localparam op_t CARRY_MASK =
      (op_t'(1) << OP_ADD) | (op_t'(1) << OP_SUB) | (op_t'(1) << OP_CMP) |
      (op_t'(1) << OP_NEG) | (op_t'(1) << OP_SHL) | (op_t'(1) << OP_SHR);

  // True when exactly one bit is set (x & (x-1) clears the lowest set bit).
  function automatic logic is_onehot(input op_t op);
    return (op != '0) && ((op & (op - op_t'(1))) == '0);
  endfunction

endpackage

// File: rtl/alu_writeback_if.sv
// ---------------------------------------------------------------------------
// alu_writeback_if -- bundle of all non-clock signals of the writeback stage.
//   ALU side    : in_valid/in_ready handshake, op, result, a_msb, b_msb, dst,
//                 st_data
//   Reg file    : rf_we, rf_waddr, rf_wdata
//   Data memory : mem_req, mem_we, mem_addr, mem_wdata, mem_ack, mem_rdata
//   Status      : flag_z/c/n/v, op_err
// master = ALU + memory side, slave = the writeback stage itself.
// ---------------------------------------------------------------------------
interface alu_writeback_if #(
  parameter int WIDTH   = 16,
  parameter int RADDR_W = 3
);
  import alu_pkg::*;

  logic               in_valid;
  logic               in_ready;
  op_t                op;
  logic [WIDTH:0]     result;
  logic               a_msb;
  logic               b_msb;
  logic [RADDR_W-1:0] dst;
  logic [WIDTH-1:0]   st_data;

  logic               rf_we;
  logic [RADDR_W-1:0] rf_waddr;
  logic [WIDTH-1:0]   rf_wdata;

  logic               mem_req;
  logic               mem_we;
  logic [WIDTH-1:0]   mem_addr;
  logic [WIDTH-1:0]   mem_wdata;
  logic               mem_ack;
  logic [WIDTH-1:0]   mem_rdata;

  logic               flag_z;
  logic               flag_c;
  logic               flag_n;
  logic               flag_v;
  logic               op_err;

  modport master (
    output in_valid, op, result, a_msb, b_msb, dst, st_data,
    output mem_ack, mem_rdata,
    input  in_ready, rf_we, rf_waddr, rf_wdata,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  flag_z, flag_c, flag_n, flag_v, op_err
  );

  modport slave (
    input  in_valid, op, result, a_msb, b_msb, dst, st_data,
    input  mem_ack, mem_rdata,
    output in_ready, rf_we, rf_waddr, rf_wdata,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output flag_z, flag_c, flag_n, flag_v, op_err
  );

endinterface

// File: rtl/alu_flags_calc.sv
// ---------------------------------------------------------------------------
// alu_flags_calc -- combinational next-flag computation.
//   op        in  one-hot opcode
//   result    in  ALU result, bit WIDTH is carry/borrow
//   a_msb     in  MSB of operand R1
//   b_msb     in  MSB of operand R2
//   flags_nxt out candidate flag values for this op
//   flags_upd out high when the op is one-hot and flag-updating
// ---------------------------------------------------------------------------
module alu_flags_calc
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  op_t            op,
  input  logic [WIDTH:0] result,
  input  logic           a_msb,
  input  logic           b_msb,
  output flags_t         flags_nxt,
  output logic           flags_upd
);

  logic sign;
  assign sign = result[WIDTH-1];

  always_comb begin
    // NOTE: every output gets a default first so no path through this block
    // can leave a value unassigned and infer a latch.
    flags_nxt = '0;
    flags_upd = is_onehot(op) && ((op & FLAG_MASK) != '0);

    flags_nxt.z = (result[WIDTH-1:0] == '0);
    flags_nxt.n = sign;
    flags_nxt.c = ((op & CARRY_MASK) != '0) ? result[WIDTH] : 1'b0;

    // Signed overflow: result sign disagrees with what the operand signs
    // allow. Only consulted when flags_upd says the op is one-hot.
    if (op[OP_ADD]) begin
      flags_nxt.v = (a_msb == b_msb) && (sign != a_msb);
    end else if (op[OP_SUB] || op[OP_CMP]) begin
      flags_nxt.v = (a_msb != b_msb) && (sign != a_msb);
    end else if (op[OP_NEG]) begin
      flags_nxt.v = b_msb && sign;
    end
  end

endmodule

// File: rtl/alu_writeback.sv
// ---------------------------------------------------------------------------
// alu_writeback -- writeback and flags stage behind the 16-bit ALU.
//   clk    in  clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of alu_writeback_if (handshake, register-file write,
//          data-memory port, flags, op_err)
// Each accepted result either writes the register file (next cycle), starts
// a data-memory access (LD/ST, stalling in_ready until acknowledged) or only
// updates the flags (CMP). A non-one-hot opcode is consumed and reported on
// op_err without any other side effect. Every output comes from a flop or
// from a decode of the state register.
// ---------------------------------------------------------------------------
module alu_writeback
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int RADDR_W = 3
) (
  input logic            clk,
  input logic            rst_n,
  alu_writeback_if.slave bus
);

  wb_state_e          state_q, state_d;
  logic               in_ready, mem_req, mem_we;
  logic               accept, onehot, is_mem_op;

  flags_t             flags_q, flags_nxt;
  logic               flags_upd;

  logic               st_q;      // outstanding access is a store
  logic [RADDR_W-1:0] ld_dst_q;  // destination of an outstanding load
  logic [WIDTH-1:0]   mem_addr_q, mem_wdata_q;
  logic               rf_we_q, op_err_q;
  logic [RADDR_W-1:0] rf_waddr_q;
  logic [WIDTH-1:0]   rf_wdata_q;

  assign accept    = bus.in_valid && in_ready;
  assign onehot    = is_onehot(bus.op);
  assign is_mem_op = onehot && (bus.op[OP_LD] || bus.op[OP_ST]);

  alu_flags_calc #(.WIDTH(WIDTH)) u_flags (
    .op        (bus.op),
    .result    (bus.result),
    .a_msb     (bus.a_msb),
    .b_msb     (bus.b_msb),
    .flags_nxt (flags_nxt),
    .flags_upd (flags_upd)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of process ordering.
      state_q <= WB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. mem_ack only matters in WB_MEM, so a stray ack while
  // no request is outstanding is ignored.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WB_IDLE: if (accept && is_mem_op) state_d = WB_MEM;
      WB_MEM:  if (bus.mem_ack)         state_d = st_q ? WB_IDLE : WB_LDWB;
      WB_LDWB: state_d = WB_IDLE;
      default: state_d = WB_IDLE;
    endcase
  end

  // State-decoded outputs. Because mem_req follows the state register, the
  // asynchronous reset drops it immediately.
  always_comb begin
    in_ready = (state_q == WB_IDLE);
    mem_req  = (state_q == WB_MEM);
    mem_we   = mem_req && st_q;
  end

  // Datapath registers: register-file write port, memory address/data,
  // flags and the error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q     <= '0;
      st_q        <= 1'b0;
      ld_dst_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      op_err_q    <= 1'b0;
    end else begin
      rf_we_q  <= 1'b0;
      op_err_q <= 1'b0;

      if (accept) begin
        if (!onehot) begin
          op_err_q <= 1'b1;
        end else begin
          if (flags_upd) flags_q <= flags_nxt;
          if ((bus.op & RF_WRITE_MASK) != '0) begin
            rf_we_q    <= 1'b1;
            rf_waddr_q <= bus.dst;
            rf_wdata_q <= bus.result[WIDTH-1:0];
          end
          if (is_mem_op) begin
            st_q        <= bus.op[OP_ST];
            ld_dst_q    <= bus.dst;
            mem_addr_q  <= bus.result[WIDTH-1:0];
            mem_wdata_q <= bus.st_data;
          end
        end
      end

      // Load completion: read data is valid in the ack cycle and is written
      // back while the FSM sits in WB_LDWB.
      if ((state_q == WB_MEM) && bus.mem_ack && !st_q) begin
        rf_we_q    <= 1'b1;
        rf_waddr_q <= ld_dst_q;
        rf_wdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_waddr  = rf_waddr_q;
  assign bus.rf_wdata  = rf_wdata_q;
  assign bus.flag_z    = flags_q.z;
  assign bus.flag_c    = flags_q.c;
  assign bus.flag_n    = flags_q.n;
  assign bus.flag_v    = flags_q.v;
  assign bus.op_err    = op_err_q;

endmodule

// File: tb/tb_alu_writeback.sv
// ---------------------------------------------------------------------------
// tb_alu_writeback -- scoreboard bench for alu_writeback.
// The driver pushes expected register writes, memory requests, flag changes
// and op_err pulses into queues as each op is accepted; a memory responder
// acknowledges requests (and supplies the expected load write-back); a
// negedge monitor pops and compares whatever the DUT presents.
// ---------------------------------------------------------------------------
module tb_alu_writeback;
  import alu_pkg::*;

  localparam int WIDTH   = 16;
  localparam int RADDR_W = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_writeback_if #(.WIDTH(WIDTH), .RADDR_W(RADDR_W)) bus ();

  alu_writeback #(.WIDTH(WIDTH), .RADDR_W(RADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard queues and reference state ----------------
  typedef struct {
    logic [RADDR_W-1:0] addr;
    logic [WIDTH-1:0]   data;
  } rf_exp_t;

  typedef struct {
    logic             we;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] wdata;
  } mem_exp_t;

  rf_exp_t    rf_q[$];
  mem_exp_t   mem_q[$];
  logic [3:0] flag_q[$];   // {z,c,n,v} after each change
  bit         err_q[$];

  logic [3:0]         model_flags = '0;
  bit                 pend_ld = 0;
  logic [RADDR_W-1:0] pend_dst = '0;

  // Reference model: what one accepted op must eventually cause.
  task automatic model_accept(input logic [OP_W-1:0] op, input logic [WIDTH:0] res,
                              input bit a, input bit b,
                              input logic [RADDR_W-1:0] dst,
                              input logic [WIDTH-1:0] sd);
    int         idx;
    op_idx_e    opx;
    logic [WIDTH-1:0] lo;
    bit         sign, z, c, n, v, upd;
    logic [3:0] nf;
    if ($countones(op) != 1) begin
      err_q.push_back(1'b1);
      return;
    end
    idx = 0;
    for (int i = 0; i < OP_W; i++) if (op[i]) idx = i;
    opx  = op_idx_e'(idx);
    lo   = res[WIDTH-1:0];
    sign = res[WIDTH-1];
    upd  = 1'b0;
    z = (lo == 0);
    n = sign;
    c = 1'b0;
    v = 1'b0;
    case (opx)
      OP_ST:   mem_q.push_back('{1'b1, lo, sd});
      OP_LD: begin
        mem_q.push_back('{1'b0, lo, '0});
        pend_ld  = 1;
        pend_dst = dst;
      end
      OP_CMP:  ;
      default: rf_q.push_back('{dst, lo});
    endcase
    case (opx)
      OP_ADD: begin upd = 1; c = res[WIDTH]; v = (a == b) && (sign != a); end
      OP_SUB, OP_CMP: begin upd = 1; c = res[WIDTH]; v = (a != b) && (sign != a); end
      OP_NEG: begin upd = 1; c = res[WIDTH]; v = b && sign; end
      OP_SHL, OP_SHR: begin upd = 1; c = res[WIDTH]; end
      OP_AND, OP_OR, OP_XOR, OP_NOT: upd = 1;
      default: upd = 0;
    endcase
    if (upd) begin
      nf = {z, c, n, v};
      if (nf != model_flags) flag_q.push_back(nf);
      model_flags = nf;
    end
  endtask

  // ---------------- driver ----------------
  task automatic send(input logic [OP_W-1:0] op, input logic [WIDTH:0] res,
                      input bit a, input bit b, input logic [RADDR_W-1:0] dst,
                      input logic [WIDTH-1:0] sd, output int acc);
    int waited;
    waited       = 0;
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.result   = res;
    bus.a_msb    = a;
    bus.b_msb    = b;
    bus.dst      = dst;
    bus.st_data  = sd;
    @(negedge clk);
    while (!bus.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", {31'b0, bus.in_ready}, 32'd1);
      bus.in_valid = 1'b0;
      acc = -1;
      return;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    model_accept(op, res, a, b, dst, sd);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    bus.op       = OP_W'($urandom);
    bus.result   = (WIDTH+1)'($urandom);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- memory responder ----------------
  bit               auto_ack = 1;
  int               ack_delay = -1;     // <0: random 0..3 cycles
  bit               fixed_rdata = 0;
  logic [WIDTH-1:0] rdata_val = '0;

  initial begin
    int d;
    logic [WIDTH-1:0] rd;
    forever begin
      @(negedge clk);
      if (auto_ack && rst_n && bus.mem_req) begin
        d = (ack_delay >= 0) ? ack_delay : int'($urandom_range(0, 3));
        repeat (d) @(negedge clk);
        rd = fixed_rdata ? rdata_val : WIDTH'($urandom);
        bus.mem_rdata = rd;
        bus.mem_ack   = 1'b1;
        if (pend_ld) begin
          rf_q.push_back('{pend_dst, rd});
          pend_ld = 0;
        end
        @(negedge clk);
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = WIDTH'($urandom);
      end
    end
  end

  // ---------------- monitor ----------------
  rf_exp_t    mon_rf;
  mem_exp_t   mon_mem;
  logic [3:0] seen_flags = '0;
  logic [3:0] cur_flags;
  logic       prev_req = 1'b0;
  int         last_rf_cyc = -1;
  int         err_seen = 0;
  bit         mon_err;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_req = 1'b0;
    end else begin
      if (bus.rf_we) begin
        if (rf_q.size() == 0) begin
          check("rf_unexpected_write", {31'b0, bus.rf_we}, 32'd0);
        end else begin
          mon_rf = rf_q.pop_front();
          check("rf_waddr", 32'(bus.rf_waddr), 32'(mon_rf.addr));
          check("rf_wdata", 32'(bus.rf_wdata), 32'(mon_rf.data));
        end
        last_rf_cyc = cyc;
      end
      if (bus.op_err) begin
        err_seen++;
        if (err_q.size() == 0) check("op_err_unexpected", {31'b0, bus.op_err}, 32'd0);
        else mon_err = err_q.pop_front();
      end
      cur_flags = {bus.flag_z, bus.flag_c, bus.flag_n, bus.flag_v};
      if (cur_flags != seen_flags) begin
        if (flag_q.size() == 0) check("flags_unexpected_change", 32'(cur_flags), 32'(seen_flags));
        else check("flags", 32'(cur_flags), 32'(flag_q.pop_front()));
        seen_flags = cur_flags;
      end
      if (bus.mem_req) begin
        if (!prev_req) begin
          if (mem_q.size() == 0) check("mem_unexpected_req", {31'b0, bus.mem_req}, 32'd0);
          else mon_mem = mem_q.pop_front();
        end
        check("mem_we", {31'b0, bus.mem_we}, {31'b0, mon_mem.we});
        check("mem_addr", 32'(bus.mem_addr), 32'(mon_mem.addr));
        if (mon_mem.we) check("mem_wdata", 32'(bus.mem_wdata), 32'(mon_mem.wdata));
        check("in_ready_during_mem", {31'b0, bus.in_ready}, 32'd0);
      end
      prev_req = bus.mem_req;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int a0, a1, a_ld, a_mv, a_st, e0;
    logic [OP_W-1:0] rop;
    bus.in_valid  = 1'b0;
    bus.op        = '0;
    bus.result    = '0;
    bus.a_msb     = 1'b0;
    bus.b_msb     = 1'b0;
    bus.dst       = '0;
    bus.st_data   = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;

    #12;
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("rst_mem_req",  {31'b0, bus.mem_req},  32'd0);
    check("rst_mem_we",   {31'b0, bus.mem_we},   32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr),     32'd0);
    check("rst_rf_we",    {31'b0, bus.rf_we},    32'd0);
    check("rst_op_err",   {31'b0, bus.op_err},   32'd0);
    check("rst_flags", 32'({bus.flag_z, bus.flag_c, bus.flag_n, bus.flag_v}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ADD with carry out and signed overflow, then CMP back-to-back.
    send(OP_W'(1) << OP_ADD, 17'h10000, 1, 1, 3'd3, 16'h0, a0);
    send(OP_W'(1) << OP_CMP, 17'h0FFFF, 0, 0, 3'd6, 16'h0, a1);
    check("back_to_back_accept", 32'(a1 - a0), 32'd1);
    idle(2);

    // ST with a slow ack: next op waits until the ack edge has passed.
    ack_delay = 3;
    send(OP_W'(1) << OP_ST,  17'h00040, 0, 0, 3'd1, 16'hBEEF, a_st);
    send(OP_W'(1) << OP_MOV, 17'h0ABCD, 0, 0, 3'd2, 16'h0, a_mv);
    check("st_stall_cycles", 32'(a_mv - a_st), 32'd5);
    idle(2);

    // LD acked in the first request cycle, then a stalled MOV.
    ack_delay   = 0;
    fixed_rdata = 1;
    rdata_val   = 16'h1234;
    send(OP_W'(1) << OP_LD,  17'h00012, 0, 0, 3'd5, 16'h0, a_ld);
    send(OP_W'(1) << OP_MOV, 17'h05555, 0, 0, 3'd4, 16'h0, a_mv);
    check("ld_write_cycle", 32'(last_rf_cyc - a_ld), 32'd1);
    check("ld_stall_cycles", 32'(a_mv - a_ld), 32'd3);
    fixed_rdata = 0;
    ack_delay   = -1;
    idle(2);

    // Non-one-hot opcodes.
    e0 = err_seen;
    send((OP_W'(1) << OP_ADD) | (OP_W'(1) << OP_SUB), 17'h00000, 1, 0, 3'd7, 16'h0, a0);
    send('0, 17'h1FFFF, 1, 1, 3'd7, 16'h0, a1);
    idle(2);
    check("op_err_pulses", 32'(err_seen - e0), 32'd2);

    // Reset while a load waits for its ack.
    auto_ack = 0;
    send(OP_W'(1) << OP_LD, 17'h00077, 0, 0, 3'd2, 16'h0, a_ld);
    idle(3);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_mem_req",  {31'b0, bus.mem_req},  32'd0);
    check("abort_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("abort_flags", 32'({bus.flag_z, bus.flag_c, bus.flag_n, bus.flag_v}), 32'd0);
    model_flags = '0;
    seen_flags  = '0;
    pend_ld     = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 16'hDEAD;
    @(negedge clk);
    bus.mem_ack   = 1'b0;
    idle(3);
    check("post_reset_in_ready", {31'b0, bus.in_ready}, 32'd1);
    auto_ack = 1;

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) rop = OP_W'($urandom);
      else rop = OP_W'(1) << $urandom_range(0, OP_W - 1);
      send(rop, (WIDTH+1)'($urandom), 1'($urandom), 1'($urandom),
           RADDR_W'($urandom), WIDTH'($urandom), a0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(12);

    check("rf_queue_drained",   32'(rf_q.size()),   32'd0);
    check("mem_queue_drained",  32'(mem_q.size()),  32'd0);
    check("flag_queue_drained", 32'(flag_q.size()), 32'd0);
    check("err_queue_drained",  32'(err_q.size()),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
